// File: rtl/nanci_shear_pe.sv
// One processing element of the Nanci mesh: holds a {addr, data} record and runs a lockstep shearsort.
// Optional feature macro: NANCI_PE_TIEBREAK_EN (equal data ranks by addr).
module nanci_shear_pe #(
    parameter int unsigned DATA_WIDTH  = 3,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SQRT_N      = 2,
    parameter int unsigned ROW         = 0,
    parameter int unsigned COL         = 0,
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_load_valid,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_load,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_l,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_r,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_u,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE_d,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_PE,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int unsigned W  = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned P  = 2 * $clog2(SQRT_N) + 1;
    localparam int unsigned SW = $clog2(SQRT_N + 1);
    localparam int unsigned PW = $clog2(P + 1);
    localparam int unsigned CW = $clog2(STEP_CYCLES + 1);
`ifdef NANCI_PE_TIEBREAK_EN
    localparam int unsigned KW = W;
`else
    localparam int unsigned KW = DATA_WIDTH;
`endif

    localparam logic ROW_ODD = (ROW % 2) == 1;
    localparam logic COL_ODD = (COL % 2) == 1;
    localparam logic HAS_L   = COL != 0;
    localparam logic HAS_R   = COL != SQRT_N - 1;
    localparam logic HAS_U   = ROW != 0;
    localparam logic HAS_D   = ROW != SQRT_N - 1;

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_COL, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_step,  w_step_nxt;
    logic [PW-1:0]   r_phase, w_phase_nxt;
    logic [CW-1:0]   r_cyc,   w_cyc_nxt;
    logic [W-1:0]    r_pe,    w_pe_nxt;
    logic            r_busy,  w_busy_nxt;
    logic            r_done,  w_done_nxt;

    logic            w_fwd;
    logic            w_present;
    logic            w_keep_min;
    logic            w_take;
    logic [W-1:0]    w_partner;
    logic [W-1:0]    w_xchg;

    // Sort key: data alone, or data then addr when ties are broken.
    function automatic logic [KW-1:0] rank_key(input logic [W-1:0] rec);
`ifdef NANCI_PE_TIEBREAK_EN
        return {rec[DATA_WIDTH-1:0], rec[W-1:DATA_WIDTH]};
`else
        return rec[DATA_WIDTH-1:0];
`endif
    endfunction

    // Partner selection and compare-exchange result for the current step.
    always_comb begin
        w_fwd      = 1'b0;
        w_present  = 1'b0;
        w_keep_min = 1'b0;
        w_partner  = '0;
        if (r_state == S_COL) begin
            w_fwd      = ~(r_step[0] ^ ROW_ODD);
            w_partner  = w_fwd ? i_PE_d : i_PE_u;
            w_present  = w_fwd ? HAS_D : HAS_U;
            w_keep_min = w_fwd;
        end else begin
            w_fwd      = ~(r_step[0] ^ COL_ODD);
            w_partner  = w_fwd ? i_PE_r : i_PE_l;
            w_present  = w_fwd ? HAS_R : HAS_L;
            w_keep_min = w_fwd ^ ROW_ODD;
        end
        w_take = w_present && (w_keep_min ? (rank_key(w_partner) < rank_key(r_pe))
                                          : (rank_key(w_partner) > rank_key(r_pe)));
        w_xchg = w_take ? w_partner : r_pe;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step  <= '0;
            r_phase <= '0;
            r_cyc   <= '0;
            r_pe    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_step  <= w_step_nxt;
            r_phase <= w_phase_nxt;
            r_cyc   <= w_cyc_nxt;
            r_pe    <= w_pe_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state: load/start in IDLE/DONE, step/phase sequencing while sorting.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_phase_nxt = r_phase;
        w_cyc_nxt   = r_cyc;
        w_pe_nxt    = r_pe;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_load_valid) begin
                    w_pe_nxt    = i_load;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (i_start) begin
                    w_state_nxt = S_ROW;
                    w_step_nxt  = '0;
                    w_phase_nxt = '0;
                    w_cyc_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                end
            end
            S_ROW, S_COL: begin
                if (r_cyc == CW'(STEP_CYCLES - 1)) begin
                    w_cyc_nxt = '0;
                    w_pe_nxt  = w_xchg;
                    if (r_step == SW'(SQRT_N - 1)) begin
                        w_step_nxt = '0;
                        if (r_phase == PW'(P - 1)) begin
                            w_state_nxt = S_DONE;
                            w_phase_nxt = '0;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_phase_nxt = r_phase + PW'(1);
                            w_state_nxt = r_phase[0] ? S_ROW : S_COL;
                        end
                    end else begin
                        w_step_nxt = r_step + SW'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_PE   = r_pe;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: doc/nanci_shear_pe.md
# nanci_shear_pe

Parametrised mesh sorting processing element for the Nanci array. Each instance holds one record `{addr, data}` and runs a complete shearsort in lockstep with its neighbours, using odd-even transposition compare-exchange. Row phases alternate snake direction; column phases sort top-to-bottom. Generalises the single-step PE with:
- configurable mesh size
- configurable step length
- runtime load and start handshake
- busy/done status
- optional tie-break

## Interface
Parameters:
- `DATA_WIDTH`, 3: sort key width.
- `ADDR_WIDTH`, 3: payload/tag width.
- `SQRT_N`, 2: mesh side length, ≥2.
- `ROW`, 0: row index of this PE, 0..SQRT_N-1.
- `COL`, 0: column index of this PE, 0..SQRT_N-1.
- `STEP_CYCLES`, 1: cycles per compare-exchange step, ≥1.

Ports (W = ADDR_WIDTH+DATA_WIDTH; records are packed `{addr[W-1:DATA_WIDTH], data[DATA_WIDTH-1:0]}`):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_start` in 1: start sort; single-cycle pulse, common to all PEs.
- `i_load_valid` in 1: load `i_load` into the held record.
- `i_load` in W: record to load.
- `i_PE_l` / `i_PE_r` / `i_PE_u` / `i_PE_d` in W: `o_PE` of the left, right, up and down neighbours.
- `o_PE` out W: held record, registered.
- `o_busy` out 1: high while sorting.
- `o_done` out 1: high from sort completion until the next start, load or reset.

## Operation
- States: IDLE, ROW, COL, DONE.
- Phases: P = 2*$clog2(SQRT_N)+1. Phase p even → ROW; p odd → COL. The last phase is always ROW.
- Each phase has SQRT_N steps, indexed s.

Row step:
- If (s+COL) is even, the partner is right (`i_PE_r`, absent if COL=SQRT_N-1).
- Otherwise the partner is left (`i_PE_l`, absent if COL=0).
- ROW even: ascending. The lower-column PE keeps min, the higher-column PE keeps max.
- ROW odd: descending. The lower-column PE keeps max.

Column step:
- If (s+ROW) is even, the partner is down (`i_PE_d`, absent if ROW=SQRT_N-1).
- Otherwise the partner is up (`i_PE_u`, absent if ROW=0).
- The lower-row PE keeps min.

General rules:
- Absent partner → hold the record. Neighbour inputs at mesh edges are don't-care.
- Compare is unsigned on `data` only; `addr` travels with its `data`.
- Equal keys → keep own record, unless tie-break is enabled (see Configuration).

Transitions:
- IDLE/DONE + `i_start` → ROW, with p=0, s=0 and step-cycle counter 0.
- After the last step of phase p: go to the next phase, or to DONE after phase P-1.
- `i_load_valid` in IDLE/DONE → `o_PE <= i_load` and `o_done` cleared. It takes priority over a same-cycle `i_start`, which is ignored.
- `i_load_valid` and `i_start` are ignored in ROW/COL.

## Timing
- Reset values: `o_PE`=0, `o_busy`=0, `o_done`=0; state IDLE; all counters 0.
- Reset mid-sort aborts immediately to the reset values.
- `o_busy` rises the cycle after `i_start` is sampled.
- Each step lasts STEP_CYCLES cycles. `o_PE` updates at the clock edge ending the step, using neighbour values sampled at that edge. Neighbours are stable for the whole step because all PEs step in lockstep.
- Total sort: P*SQRT_N*STEP_CYCLES cycles. On the edge ending the last step: `o_busy` falls, `o_done` rises and the final `o_PE` value appears.
- Load latency: 1 cycle.
- Counter widths: s is $clog2(SQRT_N+1) bits, p is $clog2(P+1) bits, and the step-cycle counter is $clog2(STEP_CYCLES+1) bits. No wrap occurs within a sort.

## Configuration
- `NANCI_PE_TIEBREAK_EN` defined: on equal `data`, the record with the smaller `addr` ranks lower, giving a total order and a deterministic result.
- `NANCI_PE_TIEBREAK_EN` undefined: equal keys hold their own record; compare logic is `data` only.

## Test plan
Defaults unless stated (SQRT_N=2, STEP_CYCLES=1, P=3).
- Reset: drive `rst`=0 mid-stimulus → `o_PE`=000000, `o_busy`=0 and `o_done`=0 immediately. After release, state is IDLE.
- Row ascending hold (ROW=0, COL=0): load 000101, `i_PE_r`=010110, pulse start →
  - step 0, partner right: keep min, `o_PE`=000101;
  - step 1, no left neighbour: still 000101.
- Row descending swap (ROW=1, COL=0): load 000101, `i_PE_r`=010110, start → `o_PE`=010110 after the first step.
- Tie (ROW=0, COL=0): load 011101, `i_PE_r`=001101, start →
  - with the macro: `o_PE`=001101 after step 0;
  - without it: `o_PE`=011101.
- Timing (STEP_CYCLES=2): start pulsed at cycle t →
  - `o_busy` is high for cycles t+1..t+12;
  - `o_done` rises at edge t+12;
  - `o_PE` changes only on even-offset edges.
- Priority: `i_load_valid` and `i_start` in the same cycle → the record is loaded, `o_busy` stays 0. A load during ROW is ignored and `o_PE` is unchanged by it.
